// File: rtl/timer0_peripheral.sv
// Timer0 peripheral for the midrange PIC16F core: TMR0, OPTION_REG, prescaler and Q-cycle divider.
// Define TIMER0_EXT_CLK_EN to build the t0cki synchronizer and external count source.
module timer0_peripheral (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] extern_peripherals_addr,
    input  logic [7:0] extern_peripherals_data_in,
    input  logic       extern_peripherals_wr_en,
    output logic [7:0] extern_peripherals_data_out,
    input  logic       t0cki,
    output logic [7:0] option_reg_out,
    output logic       t0if_set
);

    logic [7:0] tmr0;
    logic [7:0] option_reg;
    logic [7:0] prescaler;
    logic [1:0] q_phase;
    logic [1:0] inhibit;

    logic       tick;
    logic       sel_tmr0;
    logic       sel_option;
    logic       wr_tmr0;
    logic       wr_option;
    logic       src_event;
    logic       count_en;
    logic       tmr0_inc;
    logic [7:0] ps_mask;

    // Bit 8 is the bank-pair select, so both banks alias onto the same registers.
    assign sel_tmr0   = (extern_peripherals_addr[7:0] == 8'h01);
    assign sel_option = (extern_peripherals_addr[7:0] == 8'h81);
    assign wr_tmr0    = extern_peripherals_wr_en && sel_tmr0;
    assign wr_option  = extern_peripherals_wr_en && sel_option;

    assign tick = (q_phase == 2'd3);

`ifdef TIMER0_EXT_CLK_EN
    logic t0_sync_p0;
    logic t0_sync_p1;
    logic t0_prev_p2;
    logic ext_edge;

    // Two-flop synchronizer, then one flop of history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            t0_sync_p0 <= 1'b0;
            t0_sync_p1 <= 1'b0;
            t0_prev_p2 <= 1'b0;
        end else begin
            t0_sync_p0 <= t0cki;
            t0_sync_p1 <= t0_sync_p0;
            t0_prev_p2 <= t0_sync_p1;
        end
    end

    assign ext_edge  = option_reg[4] ? (t0_prev_p2 & ~t0_sync_p1)
                                     : (~t0_prev_p2 & t0_sync_p1);
    assign src_event = option_reg[5] ? ext_edge : tick;
`else
    logic unused_t0cki;
    assign unused_t0cki = t0cki;
    assign src_event    = tick;
`endif

    // PS selects a 2^(PS+1) ratio; at PS=7 the shift wraps to zero and the mask becomes 0xFF.
    assign ps_mask  = (8'd2 << option_reg[2:0]) - 8'd1;
    assign count_en = src_event && (inhibit == 2'd0);
    assign tmr0_inc = count_en && (option_reg[3] || ((prescaler & ps_mask) == ps_mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr0       <= 8'h00;
            option_reg <= 8'hFF;
            prescaler  <= 8'h00;
            q_phase    <= 2'd0;
            inhibit    <= 2'd0;
            t0if_set   <= 1'b0;
        end else begin
            q_phase  <= q_phase + 2'd1;
            t0if_set <= tmr0_inc && (tmr0 == 8'hFF) && !wr_tmr0;

            if (wr_tmr0) begin
                tmr0 <= extern_peripherals_data_in;
            end else if (tmr0_inc) begin
                tmr0 <= tmr0 + 8'd1;
            end

            if (wr_tmr0) begin
                inhibit <= 2'd2;
            end else if (tick && (inhibit != 2'd0)) begin
                inhibit <= inhibit - 2'd1;
            end

            if (wr_option) begin
                option_reg <= extern_peripherals_data_in;
            end

            // Reassigning the prescaler between Timer0 and the WDT side restarts it.
            if (wr_tmr0 || (wr_option && (extern_peripherals_data_in[3] != option_reg[3]))) begin
                prescaler <= 8'h00;
            end else if (count_en && !option_reg[3]) begin
                prescaler <= prescaler + 8'd1;
            end
        end
    end

    always_comb begin
        extern_peripherals_data_out = 8'h00;
        if (sel_tmr0) begin
            extern_peripherals_data_out = tmr0;
        end else if (sel_option) begin
            extern_peripherals_data_out = option_reg;
        end
    end

    assign option_reg_out = option_reg;

endmodule
